// File: rtl/aes_seq_pkg.sv
// Shared types and round-count constants for the AES round sequencer.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KEY_128  = 2'd0,
    KEY_192  = 2'd1,
    KEY_256  = 2'd2,
    KEY_RSVD = 2'd3
  } key_size_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Wait counter only ever needs to reach 7.
  localparam int CW = 3;

  function automatic int nr_of(input key_size_t ks);
    case (ks)
      KEY_192: return NR_192;
      KEY_256: return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_nextstate.sv
// Combinational next-state, wait-counter and round-index logic for the sequencer.
module aes_round_sequencer_nextstate
  import aes_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RW          = 4
) (
  input  state_t          state,
  input  logic [CW-1:0]   counter,
  input  logic [RW-1:0]   round,
  input  logic [RW-1:0]   nr,
  input  logic            load,
  input  logic            abort,
  output state_t          nextstate,
  output logic [CW-1:0]   nextcounter,
  output logic [RW-1:0]   nextround
);

  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

  always_comb begin
    nextstate   = state;
    nextcounter = counter;
    nextround   = round;
    if (abort) begin
      nextstate   = IDLE;
      nextcounter = '0;
      nextround   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            nextstate   = INIT;
            nextcounter = '0;
            nextround   = '0;
          end
        end
        INIT: begin
          nextstate   = ROUND;
          nextcounter = '0;
          nextround   = RW'(1);
        end
        ROUND: begin
          // >= keeps the counter bounded even if it were ever corrupted.
          if (counter >= WAIT_LAST) begin
            nextcounter = '0;
            if (round < nr) begin
              nextround = round + 1'b1;
            end else begin
              nextstate = DONE;
            end
          end else begin
            nextcounter = counter + 1'b1;
          end
        end
        DONE: begin
          if (load) begin
            nextstate   = INIT;
            nextcounter = '0;
            nextround   = '0;
          end
        end
        default: begin
          nextstate   = IDLE;
          nextcounter = '0;
          nextround   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 round controller: sequences round index and enable strobes
// with a configurable per-round wait; outputs are registered from next-state values.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RW          = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [1:0]    key_size,
  input  logic          abort,
  output logic [RW-1:0] round,
  output logic          round_en,
  output logic          first_round,
  output logic          mix_en,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

  state_t        state_reg, state_next;
  logic [CW-1:0] counter_reg, counter_next;
  logic [RW-1:0] round_reg, round_next;
  logic [RW-1:0] nr_reg, nr_next;
  logic          load_accept;
  logic          round_en_reg, first_round_reg, mix_en_reg, busy_reg, done_reg;

  aes_round_sequencer_nextstate #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .RW         (RW)
  ) u_nextstate (
    .state      (state_reg),
    .counter    (counter_reg),
    .round      (round_reg),
    .nr         (nr_reg),
    .load       (load),
    .abort      (abort),
    .nextstate  (state_next),
    .nextcounter(counter_next),
    .nextround  (round_next)
  );

  // Nr only changes when a load is actually accepted, never mid-operation.
  assign load_accept = load && !abort && (state_reg == IDLE || state_reg == DONE);
  assign nr_next     = load_accept ? RW'(nr_of(key_size_t'(key_size))) : nr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      counter_reg     <= '0;
      round_reg       <= '0;
      nr_reg          <= RW'(NR_128);
      round_en_reg    <= 1'b0;
      first_round_reg <= 1'b0;
      mix_en_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      counter_reg     <= counter_next;
      round_reg       <= round_next;
      nr_reg          <= nr_next;
      round_en_reg    <= (state_next == INIT) ||
                         (state_next == ROUND && counter_next == WAIT_LAST);
      first_round_reg <= (state_next == INIT);
      mix_en_reg      <= (state_next == ROUND) && (round_next < nr_next);
      busy_reg        <= (state_next == INIT) || (state_next == ROUND);
      done_reg        <= (state_next == DONE);
    end
  end

  assign round       = round_reg;
  assign round_en    = round_en_reg;
  assign first_round = first_round_reg;
  assign mix_en      = mix_en_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance,
// each checked every cycle against a cycle-offset model, plus directed literal checks.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       load_a = 1'b0, abort_a = 1'b0;
  logic [1:0] key_a = 2'd0;
  logic       load_b = 1'b0, abort_b = 1'b0;
  logic [1:0] key_b = 2'd0;

  logic [3:0] round_a, round_b;
  logic round_en_a, first_a, mix_a, busy_a, done_a;
  logic round_en_b, first_b, mix_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.WAIT_CYCLES(2), .RW(4)) dut_a (
    .clk(clk), .reset_n(rst_n), .load(load_a), .key_size(key_a), .abort(abort_a),
    .round(round_a), .round_en(round_en_a), .first_round(first_a),
    .mix_en(mix_a), .busy(busy_a), .done(done_a)
  );

  aes_round_sequencer #(.WAIT_CYCLES(0), .RW(4)) dut_b (
    .clk(clk), .reset_n(rst_n), .load(load_b), .key_size(key_b), .abort(abort_b),
    .round(round_b), .round_en(round_en_b), .first_round(first_b),
    .mix_en(mix_b), .busy(busy_b), .done(done_b)
  );

  // Model: an operation is described only by the cycle offset k since its load.
  typedef struct packed { bit active; int k; int nr; } mstate_t;
  typedef struct packed { int round; bit en; bit first; bit mix; bit busy; bit done; } mexp_t;

  mstate_t ma = '0;
  mstate_t mb = '0;

  function automatic int nr_for(input logic [1:0] ks);
    if (ks == 2'd1) return 12;
    if (ks == 2'd2) return 14;
    return 10;
  endfunction

  function automatic mstate_t step(input mstate_t m, input logic ld, input logic ab,
                                   input logic [1:0] ks, input int w);
    mstate_t n;
    bit in_done;
    n = m;
    in_done = m.active && (m.k >= 2 + m.nr * (w + 1));
    if (ab) begin
      n.active = 1'b0;
    end else if (ld && (!m.active || in_done)) begin
      n.active = 1'b1;
      n.k = 1;
      n.nr = nr_for(ks);
    end else if (m.active && m.k < 1000) begin
      n.k = m.k + 1;
    end
    return n;
  endfunction

  function automatic mexp_t expect_of(input mstate_t m, input int w);
    mexp_t e;
    int j;
    e = '0;
    if (m.active) begin
      if (m.k == 1) begin
        e.en = 1'b1; e.first = 1'b1; e.busy = 1'b1;
      end else if (m.k <= 1 + m.nr * (w + 1)) begin
        j = m.k - 2;
        e.round = j / (w + 1) + 1;
        e.en    = (j % (w + 1)) == w;
        e.mix   = e.round < m.nr;
        e.busy  = 1'b1;
      end else begin
        e.done  = 1'b1;
        e.round = m.nr;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, load_a, abort_a, key_a, 2);
      mb <= step(mb, load_b, abort_b, key_b, 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    mexp_t ea, eb;
    ea = expect_of(ma, 2);
    eb = expect_of(mb, 0);
    chk("a_round", round_a, ea.round);  chk("a_round_en", round_en_a, ea.en);
    chk("a_first", first_a, ea.first);  chk("a_mix", mix_a, ea.mix);
    chk("a_busy", busy_a, ea.busy);     chk("a_done", done_a, ea.done);
    chk("b_round", round_b, eb.round);  chk("b_round_en", round_en_b, eb.en);
    chk("b_first", first_b, eb.first);  chk("b_mix", mix_b, eb.mix);
    chk("b_busy", busy_b, eb.busy);     chk("b_done", done_b, eb.done);
  end

  // mode 1: re-assert load with key_size=2 during round 5 (must be ignored).
  task automatic run_a(input logic [1:0] ks, input int mode, input int exp_lat,
                       input int exp_pulses, input int exp_round, input int exp_mix);
    int lat, pulses, mixes;
    bit inj;
    lat = 0; pulses = 0; mixes = 0; inj = 1'b0;
    load_a = 1'b1; key_a = ks;
    @(negedge clk);
    load_a = 1'b0;
    chk("a_init_busy", busy_a, 1);
    chk("a_init_first", first_a, 1);
    chk("a_init_done_low", done_a, 0);
    while (!done_a && lat < 200) begin
      if (round_en_a) pulses++;
      if (mix_a) mixes++;
      lat++;
      if (mode == 1 && round_a == 4'd5 && !inj) begin
        load_a = 1'b1; key_a = 2'd2; inj = 1'b1;
      end else begin
        load_a = 1'b0;
      end
      @(negedge clk);
    end
    load_a = 1'b0;
    chk("a_latency", lat, exp_lat);
    chk("a_pulses", pulses, exp_pulses);
    chk("a_final_round", round_a, exp_round);
    chk("a_mix_cycles", mixes, exp_mix);
  endtask

  task automatic abort_test_a();
    int n, dones;
    n = 0; dones = 0;
    load_a = 1'b1; key_a = 2'd0;
    @(negedge clk);
    load_a = 1'b0;
    while (round_a != 4'd7 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("a_reached_round7", round_a, 7);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("a_abort_round", round_a, 0);
    chk("a_abort_busy", busy_a, 0);
    chk("a_abort_done", done_a, 0);
    repeat (40) begin
      if (done_a) dones++;
      @(negedge clk);
    end
    chk("a_abort_no_done", dones, 0);
  endtask

  task automatic run_b(output int lat, output int pulses);
    lat = 0; pulses = 0;
    load_b = 1'b1; key_b = 2'd0;
    @(negedge clk);
    load_b = 1'b0;
    while (!done_b && lat < 200) begin
      if (round_en_b) pulses++;
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, pulses;
    repeat (3) @(negedge clk);
    chk("rst_round", round_a, 0);
    chk("rst_round_en", round_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_a(2'd0, 0, 31, 11, 10, 27);
    repeat (3) @(negedge clk);
    chk("a_done_held", done_a, 1);
    run_a(2'd2, 0, 43, 15, 14, 39);
    run_a(2'd1, 0, 37, 13, 12, 33);
    run_a(2'd0, 1, 31, 11, 10, 27);
    abort_test_a();
    run_a(2'd0, 0, 31, 11, 10, 27);

    // abort and load together while in DONE: abort wins.
    load_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0; abort_a = 1'b0;
    chk("a_abort_load_busy", busy_a, 0);
    chk("a_abort_load_done", done_a, 0);
    chk("a_abort_load_round", round_a, 0);
    @(negedge clk);
    chk("a_abort_load_stays_idle", busy_a, 0);

    run_b(lat, pulses);
    chk("b_latency", lat, 11);
    chk("b_pulses", pulses, 11);
    chk("b_final_round", round_b, 10);

    // Asynchronous reset in the middle of an operation.
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_midrun_busy", busy_b, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("b_arst_round", round_b, 0);
    chk("b_arst_round_en", round_en_b, 0);
    chk("b_arst_mix", mix_b, 0);
    chk("b_arst_busy", busy_b, 0);
    chk("b_arst_done", done_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("b_after_rst_no_done", done_b, 0);
    run_b(lat, pulses);
    chk("b_rerun_latency", lat, 11);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
